// File: rtl/mmbf_hbf_dec2_mc_pkg.sv
// Shared types and helpers for the multichannel half-band decimate-by-2 stage.
// FSM states, the half-band K derivation, and round/narrow arithmetic.
package mmbf_pkg;

    typedef enum logic [1:0] {IDLE, MAC, RND, OUT} state_t;

    // A 4K-1 tap half-band has K distinct side coefficients plus the centre tap.
    function automatic int hbf_k(input int ntaps);
        return (ntaps + 1) / 4;
    endfunction

    // Round-half-up followed by an arithmetic right shift.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                        input int shift);
        logic signed [63:0] half;
        half = 64'sd1 <<< (shift - 1);
        return (acc + half) >>> shift;
    endfunction

    function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] v,
                                                       input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/mmbf_hbf_dec2_mc_hbf_sym_mac.sv
// Symmetric pre-add multiply-accumulate slice: (a + b) * coef per enabled cycle.
// 'last' drops b so the centre tap goes through the same multiplier.
module hbf_sym_mac #(
    parameter int DATA_WIDTH  = 24,
    parameter int COEFF_WIDTH = 24,
    parameter int ACC_WIDTH   = 54
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          en,
    input  logic                          last,
    input  logic signed [DATA_WIDTH-1:0]  a,
    input  logic signed [DATA_WIDTH-1:0]  b,
    input  logic signed [COEFF_WIDTH-1:0] coef,
    output logic signed [ACC_WIDTH-1:0]   acc
);
    localparam int PROD_W = DATA_WIDTH + 1 + COEFF_WIDTH;

    logic signed [DATA_WIDTH:0]    pre;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_WIDTH-1:0]   base;
    logic signed [ACC_WIDTH-1:0]   prod_ext;

    always_comb begin
        pre      = {a[DATA_WIDTH-1], a} + (last ? '0 : {b[DATA_WIDTH-1], b});
        prod     = pre * coef;
        prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
        // Clearing on the first term lets the first product load directly.
        base     = clear ? '0 : acc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= base + prod_ext;
        end
    end

endmodule

// File: rtl/mmbf_hbf_dec2_mc.sv
// Multichannel half-band decimate-by-2 stage, one symmetric MAC per clock.
// Define MMBF_HBF_SAT_EN to saturate the output; otherwise it wraps.
module mmbf_hbf_dec2_mc
    import mmbf_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int COEFF_WIDTH  = 24,
    parameter int NTAPS        = 31,
    parameter int CH_NUM       = 4,
    parameter int CH_IDX_WIDTH = 4,
    parameter int ACC_WIDTH    = 54
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             Cfg_Wr,
    input  logic [$clog2(hbf_k(NTAPS)+1)-1:0] Cfg_Addr,
    input  logic [COEFF_WIDTH-1:0]           Cfg_Data,
    output logic                             Cfg_Ack,
    input  logic                             Bypass,
    input  logic [DATA_WIDTH-1:0]            Data_In,
    input  logic                             Data_In_Valid,
    input  logic [CH_IDX_WIDTH-1:0]          Data_In_ChIdx,
    output logic                             Data_In_Ready,
    output logic [DATA_WIDTH-1:0]            Data_Out,
    output logic                             Data_Out_Valid,
    output logic [CH_IDX_WIDTH-1:0]          Data_Out_ChIdx,
    output logic                             Err_ChIdx
);
    localparam int K      = hbf_k(NTAPS);
    localparam int KW     = $clog2(K + 1);
    localparam int TAP_W  = $clog2(NTAPS);
    localparam int CHW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int CENTRE = (NTAPS - 1) / 2;

    state_t state, state_next;

    logic signed [DATA_WIDTH-1:0]  x [CH_NUM][NTAPS];
    logic [CH_NUM-1:0]             phase;
    logic signed [COEFF_WIDTH-1:0] coef [K+1];
    logic [CHW-1:0]                cur_sel;
    logic [CH_IDX_WIDTH-1:0]       cur_ch;
    logic [KW-1:0]                 mac_idx;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [63:0]            acc_ext;
    logic [DATA_WIDTH-1:0]         y;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_valid;
    logic [CH_IDX_WIDTH-1:0]       out_ch;
    logic                          err;

    logic                          accept, in_range, take, start_mac, cfg_commit, mac_last;
    logic [CHW-1:0]                in_sel;
    logic [TAP_W-1:0]              tap_a, tap_b;
    logic signed [DATA_WIDTH-1:0]  mac_a, mac_b;

    // Handshake: a sample transfers on any clock where Data_In_Valid && Data_In_Ready;
    // upstream holds Data_In/ChIdx stable until then. Ready only in IDLE, never in reset.
    assign Data_In_Ready = (state == IDLE) && !RST;
    assign accept        = Data_In_Valid && Data_In_Ready;
    assign in_range      = int'(Data_In_ChIdx) < CH_NUM;
    assign take          = accept && in_range;
    assign in_sel        = CHW'(Data_In_ChIdx);
    assign start_mac     = take && !Bypass && !phase[in_sel];
    assign cfg_commit    = (state == IDLE) && Cfg_Wr && !accept && !RST;
    assign mac_last      = (mac_idx == KW'(K));

    assign Cfg_Ack        = cfg_commit;
    assign Data_Out       = out_data;
    assign Data_Out_Valid = out_valid;
    assign Data_Out_ChIdx = out_ch;
    assign Err_ChIdx      = err;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_mac) state_next = MAC;
            MAC:     if (mac_last) state_next = RND;
            RND:     state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Side pairs walk the even taps from both ends; the final step takes the centre tap.
    always_comb begin
        tap_a = TAP_W'({mac_idx, 1'b0});
        tap_b = TAP_W'(NTAPS - 1) - tap_a;
        if (mac_last) tap_a = TAP_W'(CENTRE);
        mac_a = x[cur_sel][tap_a];
        mac_b = x[cur_sel][tap_b];
    end

    hbf_sym_mac #(
        .DATA_WIDTH (DATA_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_mac (
        .clk  (CLK),
        .rst  (RST),
        .clear(mac_idx == '0),
        .en   (state == MAC),
        .last (mac_last),
        .a    (mac_a),
        .b    (mac_b),
        .coef (coef[mac_idx]),
        .acc  (acc)
    );

    assign acc_ext = {{(64 - ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc};
`ifdef MMBF_HBF_SAT_EN
    assign y = DATA_WIDTH'(sat_narrow(round_shift(acc_ext, COEFF_WIDTH - 1), DATA_WIDTH));
`else
    assign y = DATA_WIDTH'(round_shift(acc_ext, COEFF_WIDTH - 1));
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < CH_NUM; c++)
                for (int n = 0; n < NTAPS; n++)
                    x[c][n] <= '0;
            for (int i = 0; i <= K; i++) coef[i] <= '0;
            phase     <= '0;
            cur_sel   <= '0;
            cur_ch    <= '0;
            mac_idx   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            err       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !in_range) err <= 1'b1;
            if (state == IDLE && Bypass) phase <= '0;
            if (take) begin
                x[in_sel][0] <= Data_In;
                for (int n = 1; n < NTAPS; n++) x[in_sel][n] <= x[in_sel][n-1];
                cur_sel <= in_sel;
                cur_ch  <= Data_In_ChIdx;
                if (Bypass) begin
                    out_data  <= Data_In;
                    out_ch    <= Data_In_ChIdx;
                    out_valid <= 1'b1;
                end else begin
                    phase[in_sel] <= ~phase[in_sel];
                end
            end
            if (cfg_commit && Cfg_Addr <= KW'(K)) coef[Cfg_Addr] <= Cfg_Data;
            mac_idx <= (state == MAC) ? mac_idx + 1'b1 : '0;
            if (state == RND) begin
                out_data  <= y;
                out_ch    <= cur_ch;
                out_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmbf_hbf_dec2_mc.sv
// Directed bench for mmbf_hbf_dec2_mc with hand-computed expectations.
// Expectations for the saturation case follow MMBF_HBF_SAT_EN.
module tb_mmbf_hbf_dec2_mc;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Cfg_Wr;
    logic [3:0]  Cfg_Addr;
    logic [23:0] Cfg_Data;
    logic        Cfg_Ack;
    logic        Bypass;
    logic [23:0] Data_In;
    logic        Data_In_Valid;
    logic [3:0]  Data_In_ChIdx;
    logic        Data_In_Ready;
    logic [23:0] Data_Out;
    logic        Data_Out_Valid;
    logic [3:0]  Data_Out_ChIdx;
    logic        Err_ChIdx;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    mmbf_hbf_dec2_mc dut (
        .CLK           (CLK),
        .RST           (RST),
        .Cfg_Wr        (Cfg_Wr),
        .Cfg_Addr      (Cfg_Addr),
        .Cfg_Data      (Cfg_Data),
        .Cfg_Ack       (Cfg_Ack),
        .Bypass        (Bypass),
        .Data_In       (Data_In),
        .Data_In_Valid (Data_In_Valid),
        .Data_In_ChIdx (Data_In_ChIdx),
        .Data_In_Ready (Data_In_Ready),
        .Data_Out      (Data_Out),
        .Data_Out_Valid(Data_Out_Valid),
        .Data_Out_ChIdx(Data_Out_ChIdx),
        .Err_ChIdx     (Err_ChIdx)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        Data_In_Valid = 1'b0;
        Cfg_Wr = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic write_coef(input int addr, input logic [23:0] val, input string tag);
        int n;
        @(negedge CLK);
        Cfg_Wr = 1'b1;
        Cfg_Addr = 4'(addr);
        Cfg_Data = val;
        #1;
        n = 0;
        while (!Cfg_Ack && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(tag, Cfg_Ack, 1);
        @(negedge CLK);
        Cfg_Wr = 1'b0;
    endtask

    // Presents one sample, then either waits for its output or confirms none appears.
    task automatic send_expect(input int ch, input logic [23:0] d, input bit exp_out,
                               input bit chk_data, input logic [23:0] exp_d, input string tag);
        int n;
        int lat;
        @(negedge CLK);
        Data_In = d;
        Data_In_ChIdx = 4'(ch);
        Data_In_Valid = 1'b1;
        #1;
        n = 0;
        while (!Data_In_Ready && n < 50) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk({tag, "_rdy"}, Data_In_Ready, 1);
        @(negedge CLK);
        Data_In_Valid = 1'b0;
        #1;
        if (exp_out) begin
            lat = 1;
            while (!Data_Out_Valid && lat < 40) begin
                @(negedge CLK);
                #1;
                lat++;
            end
            chk({tag, "_lat"}, lat, 11);
            chk({tag, "_ch"}, Data_Out_ChIdx, 4'(ch));
            chk({tag, "_busy"}, Data_In_Ready, 0);
            if (chk_data) chk({tag, "_data"}, Data_Out, exp_d);
        end else begin
            chk({tag, "_novalid"}, Data_Out_Valid, 0);
        end
    endtask

    logic [23:0] dc [4];
    logic [23:0] exp3 [4];
    int lat;
    int out_lat;
    logic [23:0] out_d;
    bit seen;

    initial begin
        RST = 1'b1;
        Cfg_Wr = 1'b1;
        Cfg_Addr = '0;
        Cfg_Data = '0;
        Bypass = 1'b0;
        Data_In = '0;
        Data_In_Valid = 1'b1;
        Data_In_ChIdx = '0;

        // Reset state, with strobes asserted to show they are masked.
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_ready", Data_In_Ready, 0);
        chk("rst_ack", Cfg_Ack, 0);
        chk("rst_valid", Data_Out_Valid, 0);
        chk("rst_data", Data_Out, 0);
        chk("rst_ch", Data_Out_ChIdx, 0);
        chk("rst_err", Err_ChIdx, 0);
        Cfg_Wr = 1'b0;
        Data_In_Valid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("rst_rel_ready", Data_In_Ready, 1);

        // Centre tap only: output is x[15]/2 on every odd ch0 sample.
        write_coef(8, 24'h400000, "t1_cfg");
        for (int n = 1; n <= 20; n++) begin
            if (n % 2 == 1)
                send_expect(0, 24'h200000, 1'b1, 1'b1, (n >= 17) ? 24'h100000 : 24'h0, "t1_ctr");
            else
                send_expect(0, 24'h200000, 1'b0, 1'b0, 24'h0, "t1_ctr");
        end

        // Impulse on ch1 traces c[i]/2; ch0 stays zero.
        do_reset();
        for (int i = 0; i < 8; i++) write_coef(i, 24'(32'h10000 * (i + 1)), "t2_cfg");
        write_coef(8, 24'h400000, "t2_cfg");
        send_expect(1, 24'h400000, 1'b1, 1'b1, 24'h008000, "t2_imp0");
        send_expect(0, 24'h0,      1'b1, 1'b1, 24'h000000, "t2_ch0a");
        send_expect(1, 24'h0,      1'b0, 1'b0, 24'h0,      "t2_skip");
        send_expect(1, 24'h0,      1'b1, 1'b1, 24'h010000, "t2_imp1");
        send_expect(0, 24'h0,      1'b0, 1'b0, 24'h0,      "t2_skip");
        send_expect(1, 24'h0,      1'b0, 1'b0, 24'h0,      "t2_skip");
        send_expect(1, 24'h0,      1'b1, 1'b1, 24'h018000, "t2_imp2");
        send_expect(0, 24'h0,      1'b1, 1'b1, 24'h000000, "t2_ch0b");

        // Full-scale coefficients and input: 2*X*C overflows 24 bits on the third sample.
        do_reset();
        for (int i = 0; i <= 8; i++) write_coef(i, 24'h7FFFFF, "t4_cfg");
        send_expect(0, 24'h7FFFFF, 1'b1, 1'b1, 24'h7FFFFE, "t4_one");
        send_expect(0, 24'h7FFFFF, 1'b0, 1'b0, 24'h0,      "t4_skip");
`ifdef MMBF_HBF_SAT_EN
        send_expect(0, 24'h7FFFFF, 1'b1, 1'b1, 24'h7FFFFF, "t4_sat");
`else
        send_expect(0, 24'h7FFFFF, 1'b1, 1'b1, 24'hFFFFFC, "t4_wrap");
`endif

        // Four interleaved DC channels through c[0]=0.5: y = (x0 + x30)/2, round-half-up.
        do_reset();
        write_coef(0, 24'h400000, "t3_cfg");
        dc[0] = 24'h100000; dc[1] = 24'h000000; dc[2] = 24'hF00000; dc[3] = 24'h7FFFFF;
        exp3[0] = 24'h080000; exp3[1] = 24'h000000; exp3[2] = 24'hF80000; exp3[3] = 24'h400000;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send_expect(c, dc[c], r != 1, 1'b1, exp3[c], "t3_ilv");

        // Bypass: one-cycle pass-through, and ch2 phase (1 after three samples) is cleared.
        @(negedge CLK);
        Bypass = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            Data_In = (k == 0) ? 24'h123456 : 24'h654321;
            Data_In_ChIdx = 4'd2;
            Data_In_Valid = 1'b1;
            #1;
            chk("byp_rdy", Data_In_Ready, 1);
            @(negedge CLK);
            Data_In_Valid = 1'b0;
            #1;
            chk("byp_valid", Data_Out_Valid, 1);
            chk("byp_data", Data_Out, (k == 0) ? 24'h123456 : 24'h654321);
            chk("byp_ch", Data_Out_ChIdx, 2);
            chk("byp_rdy_hold", Data_In_Ready, 1);
        end
        @(negedge CLK);
        Bypass = 1'b0;
        send_expect(2, 24'hF00000, 1'b1, 1'b1, 24'hF80000, "byp_phase");

        // Out-of-range channel, held config write, and write/sample collision.
        do_reset();
        #1;
        chk("t5_err0", Err_ChIdx, 0);
        @(negedge CLK);
        Data_In = 24'h0ABCDE;
        Data_In_ChIdx = 4'd5;
        Data_In_Valid = 1'b1;
        #1;
        chk("t5_bad_rdy", Data_In_Ready, 1);
        @(negedge CLK);
        Data_In_Valid = 1'b0;
        #1;
        chk("t5_err1", Err_ChIdx, 1);
        chk("t5_drop_valid", Data_Out_Valid, 0);
        chk("t5_drop_idle", Data_In_Ready, 1);
        repeat (3) @(negedge CLK);
        #1;
        chk("t5_err_sticky", Err_ChIdx, 1);

        @(negedge CLK);
        Data_In = 24'h200000;
        Data_In_ChIdx = 4'd0;
        Data_In_Valid = 1'b1;
        @(negedge CLK);
        Data_In_Valid = 1'b0;
        Cfg_Wr = 1'b1;
        Cfg_Addr = 4'd0;
        Cfg_Data = 24'h400000;
        #1;
        lat = 1;
        out_lat = 0;
        out_d = 24'hDEAD;
        while (!Cfg_Ack && lat < 40) begin
            if (Data_Out_Valid) begin
                out_lat = lat;
                out_d = Data_Out;
            end
            @(negedge CLK);
            #1;
            lat++;
        end
        chk("t5_ack_lat", lat, 12);
        chk("t5_out_lat", out_lat, 11);
        chk("t5_out_data", out_d, 0);
        @(negedge CLK);
        Cfg_Wr = 1'b0;

        @(negedge CLK);
        Data_In = 24'h0;
        Data_In_Valid = 1'b1;
        Cfg_Wr = 1'b1;
        Cfg_Addr = 4'd0;
        Cfg_Data = 24'h200000;
        #1;
        chk("t5_col_noack", Cfg_Ack, 0);
        @(negedge CLK);
        Data_In_Valid = 1'b0;
        #1;
        chk("t5_col_ack", Cfg_Ack, 1);
        @(negedge CLK);
        Cfg_Wr = 1'b0;
        send_expect(0, 24'h100000, 1'b1, 1'b1, 24'h040000, "t5_newcoef");
        write_coef(15, 24'h123456, "t5_bad_addr_ack");

        // Reset during MAC aborts the result and restarts ch0 phase.
        do_reset();
        @(negedge CLK);
        Data_In = 24'h000111;
        Data_In_ChIdx = 4'd0;
        Data_In_Valid = 1'b1;
        @(negedge CLK);
        Data_In_Valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("t6_rdy_rst", Data_In_Ready, 0);
        chk("t6_valid_rst", Data_Out_Valid, 0);
        RST = 1'b0;
        #1;
        chk("t6_rdy_after", Data_In_Ready, 1);
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge CLK);
            #1;
            if (Data_Out_Valid) seen = 1'b1;
        end
        chk("t6_no_output", seen, 0);
        send_expect(0, 24'h000111, 1'b1, 1'b1, 24'h0, "t6_phase");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmbf_hbf_dec2_mc.md
Name: mmbf_hbf_dec2_mc

Overview:
- Next-generation multichannel half-band decimate-by-2 stage, cascaded N deep inside the multistage decimation chain of each DDC path.
- Supersedes the fixed-size MBF stage: channel count, tap count and widths are parametrised; adds an input-ready handshake, runtime bypass, coefficient write port, and out-of-range-channel detection.
- Time-multiplexed: one symmetric pre-add MAC per clock, per-channel delay lines and per-channel decimation phase.

Parameters:
- DATA_WIDTH, 24, input/output sample width (signed).
- COEFF_WIDTH, 24, coefficient width (signed Q1.(COEFF_WIDTH-1)).
- NTAPS, 31, filter length; must equal 4K-1.
- CH_NUM, 4, active channels, 1..2^CH_IDX_WIDTH.
- CH_IDX_WIDTH, 4, channel index width.
- ACC_WIDTH, 54, accumulator width; must be at least DATA_WIDTH+COEFF_WIDTH+1+clog2(K+1).

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- Cfg_Wr  in  1  coefficient write strobe.
- Cfg_Addr  in  clog2(K+1)  0..K-1 = side coeffs c[i]; K = centre coeff.
- Cfg_Data  in  COEFF_WIDTH  coefficient value.
- Cfg_Ack  out  1  one-cycle pulse when the write is committed.
- Bypass  in  1  1 = pass-through with no filtering and no decimation.
- Data_In  in  DATA_WIDTH  input sample.
- Data_In_Valid  in  1  sample strobe.
- Data_In_ChIdx  in  CH_IDX_WIDTH  input channel.
- Data_In_Ready  out  1  stage can accept a sample this cycle.
- Data_Out  out  DATA_WIDTH  output sample.
- Data_Out_Valid  out  1  one-cycle output strobe.
- Data_Out_ChIdx  out  CH_IDX_WIDTH  output channel.
- Err_ChIdx  out  1  sticky; set when Data_In_ChIdx >= CH_NUM; cleared only by reset.

Behaviour:
- Reset:
  - All outputs 0, including Data_In_Ready while RST is high.
  - Delay lines, coefficients and per-channel phase bits cleared; FSM enters IDLE.
- Acceptance: a sample is accepted when Data_In_Valid && Data_In_Ready. Data_In_Ready = (state==IDLE) && !RST. Upstream holds the sample until it is accepted.
- Out-of-range channel: if the accepted channel is >= CH_NUM, the sample is dropped, Err_ChIdx is set, and no state changes.
- Accepted sample for channel ch:
  - Shift into x[ch][0]; x[ch][n] <= x[ch][n-1].
  - Toggle phase[ch].
  - If the new phase is 1, go to MAC; otherwise stay in IDLE with no output.
- FSM states: IDLE -> MAC (K+1 cycles) -> RND (1 cycle) -> OUT (1 cycle) -> IDLE.
- MAC:
  - Cycle i < K: acc += (x[ch][2i] + x[ch][NTAPS-1-2i]) * c[i].
  - Cycle K: acc += x[ch][(NTAPS-1)/2] * c[K].
  - Pre-add is DATA_WIDTH+1 bits; acc is cleared on MAC entry.
- RND: y = (acc + 2^(COEFF_WIDTH-2)) >>> (COEFF_WIDTH-1), i.e. round-half-up, then narrowed to DATA_WIDTH (see Optional Feature).
- OUT: Data_Out_Valid=1 for one cycle with Data_Out=y and Data_Out_ChIdx=ch.
- Latency: K+3 cycles from acceptance to Data_Out_Valid; K=8 gives 11. Next acceptance is possible on the cycle after OUT.
- Bypass (sampled in IDLE only; a change during MAC/RND/OUT takes effect on return to IDLE):
  - Each accepted sample appears on Data_Out one cycle later, with Data_Out_Valid and the same ChIdx.
  - Data_In_Ready stays 1.
  - All phase bits are held at 0; delay lines still shift.
- Coefficients:
  - Cfg_Wr is committed only in IDLE with no simultaneous accepted sample.
  - Otherwise the write is held pending until the next such cycle; Cfg_Wr must stay high until Cfg_Ack.
  - Cfg_Ack pulses on the commit cycle. Cfg_Addr > K is ignored but still acked.
- Simultaneous Cfg_Wr and sample acceptance in IDLE: the sample wins; the write commits on the next IDLE cycle.
- Reset mid-MAC: computation aborted; no Data_Out_Valid; state as at reset.

Optional Feature:
- Macro MMBF_HBF_SAT_EN.
- Defined: y saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Undefined: y is truncated to its low DATA_WIDTH bits (two's-complement wrap); saturation logic is absent.

Decomposition:
- Package mmbf_pkg:
  - FSM state enum (IDLE, MAC, RND, OUT).
  - Localparam function K(NTAPS) = (NTAPS+1)/4.
  - Round/narrow function, with a saturating variant.
- Sub-module hbf_sym_mac: pre-adder, multiplier and accumulator, with clear/enable/last controls. The top level keeps the FSM, delay lines, phase bits and coefficient registers.

Test Plan:
- Centre-tap only (c[8]=0x400000, others 0), ch0 fed 0x200000 repeatedly, NTAPS=31 -> after fill, every 2nd ch0 input gives Data_Out=0x100000, ChIdx=0, 11 cycles after acceptance.
- Impulse: c[i]=0x010000*(i+1), c[8]=0x400000; ch1 gets 0x400000 then zeros -> outputs trace c[i]/2 in decimated order (0x008000, 0x010000, ...); ch0 outputs stay 0.
- Interleave ch0/ch1/ch2/ch3 with DC 0x100000, 0, -0x100000, 0x7FFFFF -> phases independent; one output per channel per 2 own samples; no cross-talk.
- Saturation: all c=0x7FFFFF, input 0x7FFFFF -> 0x7FFFFF with MMBF_HBF_SAT_EN; wrapped value without it.
- Data_In_ChIdx=5 with CH_NUM=4 -> dropped, Err_ChIdx=1 and sticky; a following Cfg_Wr held through MAC acks only after OUT.
- RST asserted in MAC cycle 3 -> no Data_Out_Valid; Data_In_Ready=0 during RST, 1 the cycle after; ch0 phase restarts at 0.
